prime_gen: RTL

Random prime generator that drives the Miller-Rabin tester from the initiator side. It produces odd, full-width random candidates from an internal Galois LFSR and issues each one to the tester. It waits for the verdict and retries until a probable prime is found or the try budget runs out. It sits in the key-generation path, upstream of the RSA modulus/exponent logic.

---
 rtl/prime_gen.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/prime_gen.sv
// prime_gen: searches for a random probable prime by issuing LFSR candidates to a Miller-Rabin tester.
// Define PRIME_GEN_SIEVE_EN to add a trial-division pre-filter (3, 5, 7, 11, 13) ahead of the tester.
module prime_gen #(
    parameter int                    WORD_WIDTH = 32,
    parameter int                    ROUNDS     = 20,
    parameter int                    MAX_TRIES  = 1024,
    parameter logic [WORD_WIDTH-1:0] TAPS       = WORD_WIDTH'(32'h8020_0003),
    parameter logic [WORD_WIDTH-1:0] RESET_SEED = WORD_WIDTH'(32'h0000_0001)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  seed_load,
    input  logic [WORD_WIDTH-1:0] seed,
    output logic                  busy,
    output logic                  done,
    output logic                  found,
    output logic [WORD_WIDTH-1:0] prime,
    output logic [15:0]           tries,
    output logic                  mr_enable,
    output logic [WORD_WIDTH-1:0] mr_n,
    output logic [5:0]            mr_t,
    input  logic                  mr_done,
    input  logic                  mr_is_prime,
    output logic [2:0]            dbg_state
);

    // Tester handshake: mr_enable is a one-cycle request carrying mr_n/mr_t; mr_n stays
    // stable until the tester answers with a one-cycle mr_done, when mr_is_prime is valid.
    // mr_done is ignored outside WAIT, and no new request is made while a test is running.

`ifdef PRIME_GEN_SIEVE_EN
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_GEN   = 3'd1,
        S_SIEVE = 3'd2,
        S_ISSUE = 3'd3,
        S_WAIT  = 3'd4,
        S_FIN   = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_GEN   = 3'd1,
        S_ISSUE = 3'd3,
        S_WAIT  = 3'd4,
        S_FIN   = 3'd5
    } state_t;
`endif

    localparam logic [15:0]           MAX_T = 16'(MAX_TRIES);
    localparam logic [WORD_WIDTH-1:0] ONE   = WORD_WIDTH'(1);
    localparam logic [WORD_WIDTH-1:0] MSB   = ONE << (WORD_WIDTH - 1);

    state_t                state;
    state_t                state_nxt;
    logic [WORD_WIDTH-1:0] lfsr;
    logic [WORD_WIDTH-1:0] lfsr_step;
    logic [WORD_WIDTH-1:0] seed_fix;
    logic                  budget_out;

    assign lfsr_step  = (lfsr >> 1) ^ (lfsr[0] ? TAPS : '0);
    assign seed_fix   = (seed == '0) ? ONE : seed;
    assign budget_out = (tries == MAX_T);

`ifdef PRIME_GEN_SIEVE_EN
    logic [2:0]            sv_idx;
    logic [WORD_WIDTH-1:0] sv_rem;
    logic                  sv_hit;
    logic                  sv_last;

    // One small prime per SIEVE cycle; each divisor is a constant so no general divider is built.
    always_comb begin
        sv_rem = '0;
        case (sv_idx)
            3'd0:    sv_rem = mr_n % WORD_WIDTH'(3);
            3'd1:    sv_rem = mr_n % WORD_WIDTH'(5);
            3'd2:    sv_rem = mr_n % WORD_WIDTH'(7);
            3'd3:    sv_rem = mr_n % WORD_WIDTH'(11);
            default: sv_rem = mr_n % WORD_WIDTH'(13);
        endcase
    end

    assign sv_hit  = (sv_rem == '0);
    assign sv_last = (sv_idx == 3'd4);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sv_idx <= 3'd0;
        end else if (state == S_GEN) begin
            sv_idx <= 3'd0;
        end else if (state == S_SIEVE && !sv_hit && !sv_last) begin
            sv_idx <= sv_idx + 3'd1;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_GEN;
                end
            end
            S_GEN: begin
`ifdef PRIME_GEN_SIEVE_EN
                state_nxt = S_SIEVE;
`else
                state_nxt = S_ISSUE;
`endif
            end
`ifdef PRIME_GEN_SIEVE_EN
            S_SIEVE: begin
                if (sv_hit) begin
                    state_nxt = budget_out ? S_FIN : S_GEN;
                end else if (sv_last) begin
                    state_nxt = S_ISSUE;
                end
            end
`endif
            S_ISSUE: state_nxt = S_WAIT;
            S_WAIT: begin
                if (mr_done) begin
                    if (mr_is_prime || budget_out) begin
                        state_nxt = S_FIN;
                    end else begin
                        state_nxt = S_GEN;
                    end
                end
            end
            S_FIN:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign mr_enable = (state == S_ISSUE);
    assign done      = (state == S_FIN);
    assign busy      = (state != S_IDLE) && (state != S_FIN);
    assign mr_t      = 6'(ROUNDS);
    assign dbg_state = state;

    // The LFSR is never reset by start, so back-to-back searches continue one sequence.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr  <= RESET_SEED;
            mr_n  <= '0;
            tries <= '0;
            found <= 1'b0;
            prime <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (seed_load) begin
                        lfsr <= seed_fix;
                    end
                    if (start) begin
                        tries <= '0;
                        found <= 1'b0;
                        prime <= '0;
                    end
                end
                S_GEN: begin
                    lfsr <= lfsr_step;
                    mr_n <= lfsr_step | ONE | MSB;
                    if (tries != MAX_T) begin
                        tries <= tries + 16'd1;
                    end
                end
                S_WAIT: begin
                    if (mr_done && mr_is_prime) begin
                        prime <= mr_n;
                        found <= 1'b1;
                    end else if (mr_done && budget_out) begin
                        found <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
